// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and helpers for the push-button conditioner
//
// Contents:
//   btn_state_t      per-channel debounce FSM state
//   cycles_from_us   clock cycles in a given number of microseconds

package button_pkg;

    // UP_* states hold a released (high) level, DN_* a pressed (low) level.
    // *_CHECK states are timing a candidate level change.
    typedef enum logic [1:0] {
        UP_STABLE = 2'd0,
        DN_CHECK  = 2'd1,
        DN_STABLE = 2'd2,
        UP_CHECK  = 2'd3
    } btn_state_t;

    // Divide first so large clock rates do not overflow the product.
    function automatic int cycles_from_us(input int clk_hz, input int us);
        return (clk_hz / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// rtl/button_conditioner_debounce_channel.sv - one button: synchronizer, debounce FSM, strobes
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   raw            raw active-low pin, asynchronous to clk
//   level          debounced active-low level (registered)
//   press_pulse    one-cycle strobe when a press (1->0) is accepted
//   release_pulse  one-cycle strobe when a release (0->1) is accepted

module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] ONE   = CW'(1);
    // The CHECK state is entered with one stable sample already seen. With a
    // one-cycle window that first CHECK cycle must commit, so start at LAST.
    localparam logic [CW-1:0] FIRST = (DEBOUNCE_CYCLES == 1) ? LAST : ONE;

    logic          sync1_q;
    logic          sync2_q;
    btn_state_t    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    // Two-flop synchronizer; resets to the released level so a pin held low
    // through reset is seen as a fresh press afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= UP_STABLE;
            count_q   <= '0;
            level_q   <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Any sample that disagrees with the candidate level abandons the window
    // and clears the count, so a bounce never earns partial credit.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            UP_STABLE: begin
                if (!sync2_q) begin
                    state_d = DN_CHECK;
                    count_d = FIRST;
                end
            end
            DN_CHECK: begin
                if (sync2_q) begin
                    state_d = UP_STABLE;
                    count_d = '0;
                end else if (count_q == LAST) begin
                    state_d = DN_STABLE;
                    count_d = '0;
                    level_d = 1'b0;
                    press_d = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
            end
            DN_STABLE: begin
                if (sync2_q) begin
                    state_d = UP_CHECK;
                    count_d = FIRST;
                end
            end
            UP_CHECK: begin
                if (!sync2_q) begin
                    state_d = DN_STABLE;
                    count_d = '0;
                end else if (count_q == LAST) begin
                    state_d   = UP_STABLE;
                    count_d   = '0;
                    level_d   = 1'b1;
                    release_d = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
            end
            default: begin
                state_d = UP_STABLE;
                count_d = '0;
            end
        endcase
    end

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced active-low buttons for the HPS conduit plus press/release strobes
//
// Ports:
//   clk_clk          system clock
//   reset_reset_n    asynchronous active-low reset
//   buttons_raw      raw active-low pins (0 = pressed), asynchronous
//   buttons_conduit  debounced active-low levels to the HPS buttons conduit
//   press_pulse      per-button one-cycle strobe on accepted press
//   release_pulse    per-button one-cycle strobe on accepted release

module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BUTTONS   = 2,
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_US = 10_000
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [N_BUTTONS-1:0] buttons_raw,
    output logic [N_BUTTONS-1:0] buttons_conduit,
    output logic [N_BUTTONS-1:0] press_pulse,
    output logic [N_BUTTONS-1:0] release_pulse
);

    localparam int DEBOUNCE_CYCLES = cycles_from_us(CLK_HZ, DEBOUNCE_US);

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
            $error("button_conditioner: DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < N_BUTTONS; gi++) begin : g_chan
            debounce_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_chan (
                .clk          (clk_clk),
                .rst_n        (reset_reset_n),
                .raw          (buttons_raw[gi]),
                .level        (buttons_conduit[gi]),
                .press_pulse  (press_pulse[gi]),
                .release_pulse(release_pulse[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner

module tb_button_conditioner;

    localparam int D = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] raw = 2'b00;
    logic [1:0] conduit;
    logic [1:0] press;
    logic [1:0] rel;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BUTTONS  (2),
        .CLK_HZ     (1_000_000),
        .DEBOUNCE_US(10)
    ) dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .buttons_raw    (raw),
        .buttons_conduit(conduit),
        .press_pulse    (press),
        .release_pulse  (rel)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: a level flips once the pin, seen two clocks late,
    // has disagreed with it for D consecutive edges.
    logic [1:0] m_s1, m_s2, m_level, m_press, m_rel;
    int         m_run [2];

    int n_press [2];
    int n_rel [2];
    int press_edge, rel_edge;
    logic [1:0] press_val, rel_val;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at edge %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_s1 = 2'b11; m_s2 = 2'b11; m_level = 2'b11;
        m_press = 2'b00; m_rel = 2'b00;
        m_run[0] = 0; m_run[1] = 0;
    endtask

    task automatic model_edge();
        logic obs;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int ch = 0; ch < 2; ch++) begin
            obs = m_s2[ch];
            m_s2[ch] = m_s1[ch];
            m_s1[ch] = raw[ch];
            m_press[ch] = 1'b0;
            m_rel[ch] = 1'b0;
            if (obs != m_level[ch]) begin
                m_run[ch]++;
                if (m_run[ch] == D) begin
                    m_level[ch] = obs;
                    m_run[ch] = 0;
                    if (obs == 1'b0) m_press[ch] = 1'b1;
                    else m_rel[ch] = 1'b1;
                end
            end else begin
                m_run[ch] = 0;
            end
        end
    endtask

    task automatic clear_stats();
        n_press[0] = 0; n_press[1] = 0;
        n_rel[0] = 0; n_rel[1] = 0;
        press_edge = -1000; rel_edge = -1000;
        press_val = 2'b00; rel_val = 2'b00;
    endtask

    // Called at a falling edge; drives raw, advances one rising edge, checks.
    task automatic step(input logic [1:0] r);
        raw = r;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_eq("conduit", 32'(conduit), 32'(m_level));
        check_eq("press", 32'(press), 32'(m_press));
        check_eq("release", 32'(rel), 32'(m_rel));
        check_eq("press_and_release", 32'(press & rel), 32'd0);
        for (int ch = 0; ch < 2; ch++) begin
            n_press[ch] += int'(press[ch]);
            n_rel[ch] += int'(rel[ch]);
        end
        if (press != 2'b00) begin press_edge = cyc; press_val = press; end
        if (rel != 2'b00) begin rel_edge = cyc; rel_val = rel; end
        @(negedge clk);
    endtask

    task automatic hold(input logic [1:0] r, input int n);
        for (int i = 0; i < n; i++) step(r);
    endtask

    int start;

    initial begin
        model_reset();
        clear_stats();
        @(negedge clk);

        // 1: raw low through reset, fresh press after release
        #1;
        check_eq("t1_reset_conduit", 32'(conduit), 32'h3);
        check_eq("t1_reset_press", 32'(press), 32'h0);
        @(negedge clk);
        hold(2'b00, 3);
        rst_n = 1'b1;
        start = cyc + 1;
        hold(2'b00, 15);
        check_eq("t1_latency", 32'(press_edge - start + 1), 32'(D + 2));
        check_eq("t1_press_both", 32'(press_val), 32'h3);
        check_eq("t1_press_count0", 32'(n_press[0]), 32'd1);
        hold(2'b11, 15);

        // 2: clean press on channel 0 only
        clear_stats();
        start = cyc + 1;
        hold(2'b10, 30);
        check_eq("t2_latency", 32'(press_edge - start + 1), 32'(D + 2));
        check_eq("t2_press0", 32'(n_press[0]), 32'd1);
        check_eq("t2_press1", 32'(n_press[1]), 32'd0);
        hold(2'b11, 15);

        // 3: bounce restarts the window
        clear_stats();
        hold(2'b10, 5);
        hold(2'b11, 3);
        start = cyc + 1;
        hold(2'b10, 20);
        check_eq("t3_latency", 32'(press_edge - start + 1), 32'(D + 2));
        check_eq("t3_press0", 32'(n_press[0]), 32'd1);
        check_eq("t3_release0", 32'(n_rel[0]), 32'd0);
        hold(2'b11, 15);

        // 4: one cycle short of the window, then exactly the window
        clear_stats();
        hold(2'b10, D - 1);
        hold(2'b11, 15);
        check_eq("t4_short_press", 32'(n_press[0]), 32'd0);
        check_eq("t4_short_release", 32'(n_rel[0]), 32'd0);
        clear_stats();
        hold(2'b10, D);
        hold(2'b11, 15);
        check_eq("t4_exact_press", 32'(n_press[0]), 32'd1);
        check_eq("t4_exact_release", 32'(n_rel[0]), 32'd1);

        // 5: simultaneous edges on both channels
        clear_stats();
        hold(2'b00, 20);
        check_eq("t5_press_both", 32'(press_val), 32'h3);
        start = cyc + 1;
        hold(2'b11, 15);
        check_eq("t5_release_both", 32'(rel_val), 32'h3);
        check_eq("t5_rel_latency", 32'(rel_edge - start + 1), 32'(D + 2));

        // 6: asynchronous reset while held pressed
        clear_stats();
        hold(2'b00, 15);
        check_eq("t6_pressed", 32'(conduit), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_async_conduit", 32'(conduit), 32'h3);
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        clear_stats();
        start = cyc + 1;
        hold(2'b00, 15);
        check_eq("t6_latency", 32'(press_edge - start + 1), 32'(D + 2));
        check_eq("t6_press_both", 32'(press_val), 32'h3);
        hold(2'b11, 15);

        // Random bouncing on both channels against the model
        for (int seg = 0; seg < 60; seg++) begin
            hold(2'($urandom), int'($urandom_range(1, 2 * D + 4)));
        end
        hold(2'b11, 15);
        check_eq("rand_idle_conduit", 32'(conduit), 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
